transpose_stream: RTL

// - Parametrised, streaming successor to the fixed 5x5 combinational transpose used in

---
 rtl/noc_transpose_pkg.sv | 29 ++
 rtl/transpose_bank.sv | 52 +++++
 rtl/transpose_stream.sv | 131 +++++++++++++
 3 files changed

// File: rtl/noc_transpose_pkg.sv
// ---------------------------------------------------------------------------
// noc_transpose_pkg
// Shared helpers for the streaming matrix transpose.
//   clog2()  : ceiling log2 that works for any N, including non-powers of 2
//   idx_w()  : width of a row/column index for an N x N matrix (at least 1)
//   BANK0/1  : ping-pong bank select values
// ---------------------------------------------------------------------------
package noc_transpose_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/transpose_bank.sv
// ---------------------------------------------------------------------------
// transpose_bank
// One N x (N*EW) register array holding a single matrix.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset (contents cleared to 0)
//   we         : write strobe for row wrow
//   wrow       : row index being written
//   wdata      : row contents, element j at [j*EW +: EW]
//   zfill      : rows to clear in the same cycle (tail of an early-closed matrix)
//   rcol       : column index to read
//   col        : column rcol, element from row r at [r*EW +: EW]
// ---------------------------------------------------------------------------
module transpose_bank
  import noc_transpose_pkg::*;
#(
  parameter int N  = 5,
  parameter int EW = 1,
  parameter int IW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [IW-1:0]   wrow,
  input  logic [N*EW-1:0] wdata,
  input  logic [N-1:0]    zfill,
  input  logic [IW-1:0]   rcol,
  output logic [N*EW-1:0] col
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      logic [N*EW-1:0] data_reg;

      // The written row takes priority over the zero-fill mask; the top only
      // ever flags rows strictly above the one being written.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          data_reg <= '0;
        end else if (we && (wrow == IW'(gi))) begin
          data_reg <= wdata;
        end else if (we && zfill[gi]) begin
          data_reg <= '0;
        end
      end

      // Element rcol of row gi lands at position gi of the column vector.
      assign col[gi*EW +: EW] = data_reg[int'(rcol)*EW +: EW];
    end
  endgenerate

endmodule

// File: rtl/transpose_stream.sv
// ---------------------------------------------------------------------------
// transpose_stream
// Streaming N x N transpose: one row in per cycle, one column out per cycle,
// ping-pong double buffered so both sides can run continuously.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   in_valid/in_ready    : row handshake
//   in_data              : row, element j at [j*EW +: EW]
//   in_last              : closes the matrix (early close zero-fills the rest)
//   out_valid/out_ready  : column handshake
//   out_data             : column, element from row r at [r*EW +: EW]
//   out_last             : marks column N-1
// ---------------------------------------------------------------------------
module transpose_stream
  import noc_transpose_pkg::*;
#(
  parameter int N  = 5,
  parameter int EW = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*EW-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*EW-1:0] out_data,
  output logic            out_last
);

  localparam int            IW       = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic          wbank_reg, wbank_next;
  logic          rbank_reg, rbank_next;
  logic [IW-1:0] wcnt_reg,  wcnt_next;
  logic [IW-1:0] rcnt_reg,  rcnt_next;
  logic [1:0]    full_reg,  full_next;

  logic accept, close, consume, drain;

  // Ready/valid come straight from flag registers, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = ~full_reg[wbank_reg];
  assign out_valid = full_reg[rbank_reg];

  assign accept  = in_valid & in_ready;
  assign close   = accept & (in_last | (wcnt_reg == LAST_IDX));
  assign consume = out_valid & out_ready;
  assign drain   = consume & (rcnt_reg == LAST_IDX);

  // A closing write and a final read can coincide; they always hit
  // different banks (write needs ~full, read needs full), so both apply.
  always_comb begin
    wbank_next = wbank_reg;
    rbank_next = rbank_reg;
    wcnt_next  = wcnt_reg;
    rcnt_next  = rcnt_reg;
    full_next  = full_reg;
    if (accept) begin
      if (close) begin
        full_next[wbank_reg] = 1'b1;
        wbank_next           = ~wbank_reg;
        wcnt_next            = '0;
      end else begin
        wcnt_next = wcnt_reg + IW'(1);
      end
    end
    if (consume) begin
      if (drain) begin
        full_next[rbank_reg] = 1'b0;
        rbank_next           = ~rbank_reg;
        rcnt_next            = '0;
      end else begin
        rcnt_next = rcnt_reg + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbank_reg <= BANK0;
      rbank_reg <= BANK0;
      wcnt_reg  <= '0;
      rcnt_reg  <= '0;
      full_reg  <= '0;
    end else begin
      wbank_reg <= wbank_next;
      rbank_reg <= rbank_next;
      wcnt_reg  <= wcnt_next;
      rcnt_reg  <= rcnt_next;
      full_reg  <= full_next;
    end
  end

  // Rows above the closing row are cleared so an early close yields a
  // well-defined zero-padded matrix.
  logic [N-1:0]    zfill;
  logic [N*EW-1:0] col_w [2];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_zfill
      assign zfill[gi] = close && (IW'(gi) > wcnt_reg);
    end

    for (gi = 0; gi < 2; gi++) begin : g_bank
      transpose_bank #(
        .N  (N),
        .EW (EW),
        .IW (IW)
      ) u_bank (
        .clk   (clk),
        .rstn  (rstn),
        .we    (accept && (wbank_reg == 1'(gi))),
        .wrow  (wcnt_reg),
        .wdata (in_data),
        .zfill (zfill),
        .rcol  (rcnt_reg),
        .col   (col_w[gi])
      );
    end
  endgenerate

  // Stable while stalled: rbank/rcnt only move on consume, and the write
  // side never targets a full bank.
  assign out_data = col_w[rbank_reg];
  assign out_last = out_valid & (rcnt_reg == LAST_IDX);

endmodule
